// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-step shift/rotate controller that applies one 1-bit step per clock with carry chaining.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [AMT_W-1:0] amount,
  input  logic             c_in,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             z_out,
  output logic             n_out
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] r, r_n;
  logic [AMT_W-1:0] cnt, cnt_n;
  logic [2:0] op_q, op_n;
  logic c, c_n, msb, accept;
  assign ready = state != SHIFT;
  assign valid = state == DONE;
  always_comb begin
    msb = op_q == 3'd2 ? r[WIDTH-1] : op_q == 3'd3 ? r[0] : op_q == 3'd4 ? c : 1'b0;
    accept = start && ready;
    state_n = state == DONE ? IDLE : state;
    r_n = r;
    c_n = c;
    cnt_n = cnt;
    op_n = op_q;
    if (accept) begin
      r_n = operand;
      c_n = c_in;
      cnt_n = amount;
      op_n = op;
      state_n = (amount == '0 || op > 3'd4) ? DONE : SHIFT;
    end else if (state == SHIFT) begin
      r_n = op_q == 3'd0 ? {r[WIDTH-2:0], 1'b0} : {msb, r[WIDTH-1:1]};
      c_n = op_q == 3'd0 ? r[WIDTH-1] : r[0];
      cnt_n = cnt - 1'b1;
      state_n = cnt_n == '0 ? DONE : SHIFT;
    end
  end
  // Visible outputs load on the edge entering DONE so they coincide with valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      r <= '0;
      c <= 1'b0;
      cnt <= '0;
      op_q <= '0;
      result <= '0;
      c_out <= 1'b0;
      z_out <= 1'b1;
      n_out <= 1'b0;
    end else begin
      state <= state_n;
      r <= r_n;
      c <= c_n;
      cnt <= cnt_n;
      op_q <= op_n;
      if (state_n == DONE) begin
        result <= r_n;
        c_out <= c_n;
        z_out <= r_n == '0;
        n_out <= r_n[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: scoreboard bench for shift_sequencer; expectations come from a step model.
module tb_shift_sequencer;
  logic clk = 0, rst_n = 0, start = 0, c_in = 0;
  logic [2:0] op = 0;
  logic [15:0] operand = 0;
  logic [3:0] amount = 0;
  logic ready, valid, c_out, z_out, n_out;
  logic [15:0] result;
  int checks = 0, failures = 0, cyc = 0;
  logic in_done;
  typedef struct {logic [15:0] r; logic c; int cyc;} exp_t;
  exp_t q[$];

  shift_sequencer dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .operand(operand),
    .amount(amount), .c_in(c_in), .ready(ready), .valid(valid), .result(result),
    .c_out(c_out), .z_out(z_out), .n_out(n_out));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [15:0] d, input logic [3:0] a, input logic ci);
    exp_t e;
    logic [15:0] v = d;
    logic cc = ci;
    logic nc;
    if (o <= 3'd4)
      for (int i = 0; i < int'(a); i++) begin
        case (o)
          3'd0: begin nc = v[15]; v = v << 1; end
          3'd1: begin nc = v[0]; v = v >> 1; end
          3'd2: begin nc = v[0]; v = {v[15], v[15:1]}; end
          3'd3: begin nc = v[0]; v = {v[0], v[15:1]}; end
          default: begin nc = v[0]; v = {cc, v[15:1]}; end
        endcase
        cc = nc;
      end
    e.r = v;
    e.c = cc;
    e.cyc = (o <= 3'd4) ? int'(a) : 0;
    return e;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [15:0] d, input logic [3:0] a, input logic ci);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 0, 1);
    in_done = valid;
    start = 1; op = o; operand = d; amount = a; c_in = ci;
    @(posedge clk);
    #1;
    start = 0;
    e = model(o, d, a, ci);
    e.cyc += cyc;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid) begin
      if (q.size() == 0) check("spurious_valid", 1, 0);
      else begin
        e = q.pop_front();
        check("result", result, e.r);
        check("c_out", c_out, e.c);
        check("z_out", z_out, e.r == 0);
        check("n_out", n_out, e.r[15]);
        check("latency", cyc, e.cyc);
        check("ready_in_done", ready, 1);
      end
    end
  end

  initial begin
    #12;
    check("rst_ready", ready, 1);
    check("rst_valid", valid, 0);
    check("rst_result", result, 0);
    check("rst_c", c_out, 0);
    check("rst_z", z_out, 1);
    check("rst_n_out", n_out, 0);
    @(negedge clk);
    rst_n = 1;
    issue(3'd4, 16'h8001, 4'd1, 0); drain();
    issue(3'd2, 16'h8000, 4'd15, 0); drain();
    issue(3'd1, 16'h8000, 4'd15, 0); drain();
    issue(3'd3, 16'h000F, 4'd4, 0); drain();
    issue(3'd0, 16'hC000, 4'd1, 0); drain();
    issue(3'd0, 16'h1234, 4'd0, 1); drain();
    issue(3'd6, 16'h1234, 4'd9, 1); drain();
    issue(3'd1, 16'h0000, 4'd3, 1); drain();
    // Start while busy must be dropped; the follow-on op lands in the DONE cycle.
    issue(3'd0, 16'h00A5, 4'd6, 0);
    repeat (2) @(negedge clk);
    start = 1; op = 3'd1; operand = 16'hFFFF; amount = 4'd2; c_in = 1;
    @(negedge clk);
    start = 0;
    issue(3'd1, 16'h0003, 4'd1, 0);
    check("start_in_done", in_done, 1);
    drain();
    check("result_held", result, 16'h0001);
    issue(3'd7, 16'h0, 4'd0, 0); issue(3'd4, 16'h0001, 4'd3, 1); issue(3'd5, 16'hBEEF, 4'd2, 0);
    drain();
    for (int i = 0; i < 8; i++) issue(3'($urandom_range(0, 7)), 16'($urandom), 4'($urandom), 1'($urandom));
    drain();
    issue(3'd1, 16'hFFFF, 4'd10, 1);
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    q.delete();
    check("abort_ready", ready, 1);
    check("abort_valid", valid, 0);
    check("abort_result", result, 0);
    check("abort_z", z_out, 1);
    check("abort_c", c_out, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    check("abort_queue", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
